// File: rtl/matmul_mem_pkg.sv
// Shared types and helpers for the matmul scratchpad responder.
package matmul_mem_pkg;

    localparam int unsigned BUS_WIDTH  = 32;
    localparam int unsigned STRB_WIDTH = 4;

    typedef logic [BUS_WIDTH-1:0]  word_t;
    typedef logic [STRB_WIDTH-1:0] strb_t;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_e;

    // Word offset from the memory base; callers truncate to the array index width.
    function automatic word_t word_offset(input word_t addr, input word_t base);
        word_t diff;
        diff = addr - base;
        return diff >> 2;
    endfunction

endpackage

// File: rtl/mem_resp_sram.sv
// Single-port DEPTHx32 byte-enabled array; the read port returns the post-write word.
module mem_resp_sram
    import matmul_mem_pkg::*;
#(
    parameter int unsigned DEPTH = 256,
    parameter int unsigned AW    = $clog2(DEPTH)
) (
    input  logic          clk_i,
    input  logic          en_i,
    input  logic [AW-1:0] idx_i,
    input  strb_t         we_i,
    input  word_t         wdata_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;
    word_t rdata_d;

    always_comb begin
        rdata_d = mem_q[idx_i];
        for (int k = 0; k < STRB_WIDTH; k++) begin
            if (we_i[k]) begin
                rdata_d[8*k +: 8] = wdata_i[8*k +: 8];
            end
        end
    end

    // Storage is intentionally not reset; the read register is masked by the owner.
    always_ff @(posedge clk_i) begin
        if (en_i) begin
            mem_q[idx_i] <= rdata_d;
            rdata_q      <= rdata_d;
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/matmul_mem_responder.sv
// Scratchpad responder on the matmul req/gnt/ack bus with configurable wait states.
// Optional address checking is enabled by defining MATMUL_MEM_ADDR_CHECK_EN.
module matmul_mem_responder
    import matmul_mem_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
    parameter int unsigned DEPTH       = 256,
    parameter int unsigned WAIT_STATES = 1,
    parameter int unsigned DATA_WIDTH  = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  mem_req_i,
    input  logic                  mem_rd_i,
    input  logic [3:0]            mem_wr_i,
    input  logic [31:0]           mem_addr_i,
    input  logic [DATA_WIDTH-1:0] mem_data_wr_i,
    output logic [DATA_WIDTH-1:0] mem_data_rd_o,
    output logic                  mem_gnt_o,
    output logic                  mem_ack_o,
    output logic                  err_o
);

    localparam int unsigned AW        = $clog2(DEPTH);
    localparam logic [3:0]  WAIT_LAST = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    word_t       addr_q, addr_d;
    word_t       wdata_q, wdata_d;
    strb_t       strb_q, strb_d;
    logic        rd_q, rd_d;
    logic        ack_q, ack_d;
    logic        vld_q, vld_d;
    logic        err_q, err_d;

    word_t       cur_addr;
    word_t       cur_wdata;
    strb_t       cur_strb;
    logic        cur_rd;
    logic        addr_err;
    logic        sram_en;
    strb_t       sram_we;
    word_t       sram_rdata;

    // With zero wait states the commit edge is the accept edge, so use the live bus.
    always_comb begin
        if (state_q == S_IDLE) begin
            cur_addr  = mem_addr_i;
            cur_wdata = mem_data_wr_i;
            cur_strb  = mem_wr_i;
            cur_rd    = mem_rd_i;
        end else begin
            cur_addr  = addr_q;
            cur_wdata = wdata_q;
            cur_strb  = strb_q;
            cur_rd    = rd_q;
        end
    end

`ifdef MATMUL_MEM_ADDR_CHECK_EN
    localparam logic [32:0] LIMIT = {1'b0, BASE_ADDR} + 33'(4 * DEPTH);

    assign addr_err = ({1'b0, cur_addr} < {1'b0, BASE_ADDR}) ||
                      ({1'b0, cur_addr} >= LIMIT) ||
                      (cur_addr[1:0] != 2'b00);
`else
    assign addr_err = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        strb_d    = strb_q;
        rd_d      = rd_q;
        mem_gnt_o = 1'b0;

        unique case (state_q)
            S_IDLE: begin
                mem_gnt_o = mem_req_i;
                if (mem_req_i) begin
                    addr_d  = mem_addr_i;
                    wdata_d = mem_data_wr_i;
                    strb_d  = mem_wr_i;
                    rd_d    = mem_rd_i;
                    cnt_d   = 4'd0;
                    state_d = (WAIT_STATES > 0) ? S_WAIT : S_ACK;
                end
            end
            S_WAIT: begin
                if (cnt_q == WAIT_LAST) begin
                    cnt_d   = 4'd0;
                    state_d = S_ACK;
                end else begin
                    cnt_d = cnt_q + 4'd1;
                end
            end
            // Request is still high here; it is not re-accepted until S_IDLE.
            S_ACK: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign sram_en = (state_d == S_ACK);
    assign sram_we = cur_strb & {STRB_WIDTH{~addr_err}};

    always_comb begin
        ack_d = sram_en;
        vld_d = sram_en && ((cur_strb != '0) || cur_rd) && !addr_err;
        err_d = sram_en && addr_err;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= '0;
            wdata_q <= '0;
            strb_q  <= '0;
            rd_q    <= 1'b0;
            ack_q   <= 1'b0;
            vld_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            strb_q  <= strb_d;
            rd_q    <= rd_d;
            ack_q   <= ack_d;
            vld_q   <= vld_d;
            err_q   <= err_d;
        end
    end

    mem_resp_sram #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_sram (
        .clk_i   (clk_i),
        .en_i    (sram_en),
        .idx_i   (AW'(word_offset(cur_addr, BASE_ADDR))),
        .we_i    (sram_we),
        .wdata_i (cur_wdata),
        .rdata_o (sram_rdata)
    );

    assign mem_ack_o     = ack_q;
    assign mem_data_rd_o = vld_q ? sram_rdata : '0;
    assign err_o         = err_q;

endmodule
